// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one block-wide memory port between the I-cache and D-cache.
// A granted cache owns the port until its ready retires, followed by one release cycle.
module mem_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              grant_d,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GNT_I = 3'd1,
        GNT_D = 3'd2,
        REL_I = 3'd3,
        REL_D = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic              last_gnt_d_reg, last_gnt_d_next;   // 0 = I-cache was last owner
    logic [DATA_W-1:0] rdata_hold_reg;
    logic              capture;
    logic              i_req, d_req;

    assign i_req = i_mem_read | i_mem_write;
    assign d_req = d_mem_read | d_mem_write;

    assign i_mem_rdata = rdata_hold_reg;
    assign d_mem_rdata = rdata_hold_reg;

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_reg      <= IDLE;
            last_gnt_d_reg <= 1'b0;
            rdata_hold_reg <= '0;
        end else begin
            state_reg      <= state_next;
            last_gnt_d_reg <= last_gnt_d_next;
            if (capture) begin
                rdata_hold_reg <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_gnt_d_next = last_gnt_d_reg;
        capture         = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        i_mem_ready     = 1'b0;
        d_mem_ready     = 1'b0;
        grant_d         = 1'b0;
        busy            = 1'b0;

        case (state_reg)
            IDLE: begin
                // On a tie the cache that did not own the port last time wins.
                if (d_req && (!i_req || !last_gnt_d_reg)) begin
                    state_next      = GNT_D;
                    last_gnt_d_next = 1'b1;
                end else if (i_req) begin
                    state_next      = GNT_I;
                    last_gnt_d_next = 1'b0;
                end
            end
            GNT_I: begin
                busy        = 1'b1;
                mem_write   = i_mem_write;
                mem_read    = i_mem_read & ~i_mem_write;
                mem_addr    = i_mem_addr;
                mem_wdata   = i_mem_wdata;
                i_mem_ready = mem_ready;
                if (mem_ready) begin
                    capture    = 1'b1;
                    state_next = REL_I;
                end else if (!i_req) begin
                    state_next = IDLE;
                end
            end
            GNT_D: begin
                busy        = 1'b1;
                grant_d     = 1'b1;
                mem_write   = d_mem_write;
                mem_read    = d_mem_read & ~d_mem_write;
                mem_addr    = d_mem_addr;
                mem_wdata   = d_mem_wdata;
                d_mem_ready = mem_ready;
                if (mem_ready) begin
                    capture    = 1'b1;
                    state_next = REL_D;
                end else if (!d_req) begin
                    state_next = IDLE;
                end
            end
            REL_I: begin
                // Owner stays selected but strobes are quiet while the cache retires its ready.
                busy       = 1'b1;
                mem_addr   = i_mem_addr;
                mem_wdata  = i_mem_wdata;
                state_next = IDLE;
            end
            REL_D: begin
                busy       = 1'b1;
                grant_d    = 1'b1;
                mem_addr   = d_mem_addr;
                mem_wdata  = d_mem_wdata;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: an ownership-level model checks every cycle,
// and literal expectations from the test plan pin the model.
module tb_mem_port_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk;
    logic          proc_reset;
    logic          i_mem_read, i_mem_write, d_mem_read, d_mem_write;
    logic [AW-1:0] i_mem_addr, d_mem_addr, mem_addr;
    logic [DW-1:0] i_mem_wdata, d_mem_wdata, mem_wdata, mem_rdata;
    logic [DW-1:0] i_mem_rdata, d_mem_rdata;
    logic          i_mem_ready, d_mem_ready, mem_read, mem_write, mem_ready, grant_d, busy;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .proc_reset  (proc_reset),
        .i_mem_read  (i_mem_read),
        .i_mem_write (i_mem_write),
        .i_mem_addr  (i_mem_addr),
        .i_mem_wdata (i_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ready (i_mem_ready),
        .d_mem_read  (d_mem_read),
        .d_mem_write (d_mem_write),
        .d_mem_addr  (d_mem_addr),
        .d_mem_wdata (d_mem_wdata),
        .d_mem_rdata (d_mem_rdata),
        .d_mem_ready (d_mem_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .grant_d     (grant_d),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ownership model: who holds the port, whether it is in its release cycle,
    // who won last, and the last block returned by memory.
    int            m_owner;   // 0 none, 1 I-cache, 2 D-cache
    bit            m_rel;
    int            m_last;
    logic [DW-1:0] m_hold;
    logic [5:0]    e_ctrl, a_ctrl;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          o_rd, o_wr, o_req, i_req, d_req;

    initial begin
        m_owner = 0;
        m_rel   = 1'b0;
        m_last  = 1;
        m_hold  = '0;
    end

    always @(negedge clk) begin
        if (proc_reset) begin
            m_owner = 0;
            m_rel   = 1'b0;
            m_last  = 1;
            m_hold  = '0;
        end
        i_req = i_mem_read | i_mem_write;
        d_req = d_mem_read | d_mem_write;
        o_rd  = (m_owner == 1) ? i_mem_read  : (m_owner == 2) ? d_mem_read  : 1'b0;
        o_wr  = (m_owner == 1) ? i_mem_write : (m_owner == 2) ? d_mem_write : 1'b0;
        o_req = o_rd | o_wr;
        e_addr  = (m_owner == 1) ? i_mem_addr  : (m_owner == 2) ? d_mem_addr  : '0;
        e_wdata = (m_owner == 1) ? i_mem_wdata : (m_owner == 2) ? d_mem_wdata : '0;
        // {busy, grant_d, mem_read, mem_write, i_ready, d_ready}
        e_ctrl = {m_owner != 0, m_owner == 2,
                  (m_owner != 0) && !m_rel && o_rd && !o_wr,
                  (m_owner != 0) && !m_rel && o_wr,
                  (m_owner == 1) && !m_rel && mem_ready,
                  (m_owner == 2) && !m_rel && mem_ready};
        a_ctrl = {busy, grant_d, mem_read, mem_write, i_mem_ready, d_mem_ready};
        chk("cyc_ctrl", a_ctrl, e_ctrl);
        chk("cyc_addr", mem_addr, e_addr);
        chk("cyc_wdata", mem_wdata, e_wdata);
        chk("cyc_i_rdata", i_mem_rdata, m_hold);
        chk("cyc_d_rdata", d_mem_rdata, m_hold);
        if (!proc_reset) begin
            if (m_owner == 0) begin
                if (i_req && d_req) m_owner = (m_last == 1) ? 2 : 1;
                else if (d_req)     m_owner = 2;
                else if (i_req)     m_owner = 1;
                if (m_owner != 0) m_last = m_owner;
                m_rel = 1'b0;
            end else if (m_rel) begin
                m_owner = 0;
                m_rel   = 1'b0;
            end else if (mem_ready) begin
                m_hold = mem_rdata;
                m_rel  = 1'b1;
            end else if (!o_req) begin
                m_owner = 0;
            end
        end
    end

    localparam logic [DW-1:0] R_A5    = {16{8'hA5}};
    localparam logic [DW-1:0] R_D1    = {16{8'h3C}};
    localparam logic [DW-1:0] R_I2    = {16{8'h5A}};
    localparam logic [DW-1:0] R_D2    = {16{8'hC3}};
    localparam logic [DW-1:0] R_WACK  = {16{8'hEE}};
    localparam logic [DW-1:0] R_I3    = {16{8'h99}};
    localparam logic [DW-1:0] R_ALLOC = {16{8'h77}};
    localparam logic [DW-1:0] R_FF    = {16{8'hFF}};
    localparam logic [DW-1:0] W_1111  = {8{16'h1111}};

    initial begin
        proc_reset  = 1'b1;
        i_mem_read  = 1'b0; i_mem_write = 1'b0; i_mem_addr = '0; i_mem_wdata = '0;
        d_mem_read  = 1'b0; d_mem_write = 1'b0; d_mem_addr = '0; d_mem_wdata = '0;
        mem_rdata   = '0;   mem_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_i_rdata", i_mem_rdata, '0);
        #2 proc_reset = 1'b0;

        // Lone I-cache read
        tick();
        i_mem_read = 1'b1; i_mem_addr = 28'h0000123;
        #1 chk("t1_c0_idle", busy, 1'b0);
        tick();
        chk("t1_mem_read", mem_read, 1'b1);
        chk("t1_mem_addr", mem_addr, 28'h0000123);
        chk("t1_grant_d", grant_d, 1'b0);
        tick(); tick(); tick();
        mem_ready = 1'b1; mem_rdata = R_A5;
        #1 chk("t1_i_ready", i_mem_ready, 1'b1);
        chk("t1_d_ready", d_mem_ready, 1'b0);
        tick();
        mem_ready = 1'b0; mem_rdata = '0; i_mem_read = 1'b0;
        #1 chk("t1_i_rdata", i_mem_rdata, R_A5);
        chk("t1_rel_read", mem_read, 1'b0);
        chk("t1_rel_busy", busy, 1'b1);
        tick();
        chk("t1_c6_idle", busy, 1'b0);
        $display("txn lone_i_read done at %0t", $time);

        // Tie after I-cache last won: D first, then I, then D wins the next tie
        i_mem_read = 1'b1; i_mem_addr = 28'h0000200;
        d_mem_read = 1'b1; d_mem_addr = 28'h0000300;
        tick();
        chk("t2_grant_d", grant_d, 1'b1);
        chk("t2_d_addr", mem_addr, 28'h0000300);
        tick();
        mem_ready = 1'b1; mem_rdata = R_D1;
        #1 chk("t2_d_ready", d_mem_ready, 1'b1);
        chk("t2_i_ready_off", i_mem_ready, 1'b0);
        tick();
        mem_ready = 1'b0; d_mem_read = 1'b0;
        #1 chk("t2_d_rdata", d_mem_rdata, R_D1);
        tick();
        chk("t2_idle_gap", busy, 1'b0);
        tick();
        chk("t2_i_granted", {busy, grant_d}, 2'b10);
        chk("t2_i_addr", mem_addr, 28'h0000200);
        tick();
        mem_ready = 1'b1; mem_rdata = R_I2;
        #1 chk("t2_i_ready", i_mem_ready, 1'b1);
        tick();
        mem_ready = 1'b0; i_mem_read = 1'b0;
        tick();
        i_mem_read = 1'b1; d_mem_read = 1'b1;
        tick();
        chk("t2_tie2_d", grant_d, 1'b1);
        tick();
        mem_ready = 1'b1; mem_rdata = R_D2;
        tick();
        mem_ready = 1'b0; d_mem_read = 1'b0; i_mem_read = 1'b0;
        tick();
        $display("txn tie_round_robin done at %0t", $time);

        // D write-back, release, then allocate; pending I wins the gap
        d_mem_write = 1'b1; d_mem_addr = 28'h0000040; d_mem_wdata = W_1111;
        tick();
        chk("t3_mem_write", {mem_write, mem_read}, 2'b10);
        chk("t3_wdata", mem_wdata, W_1111);
        chk("t3_waddr", mem_addr, 28'h0000040);
        i_mem_read = 1'b1; i_mem_addr = 28'h0000600;
        tick();
        chk("t3_write_held", mem_write, 1'b1);
        mem_ready = 1'b1; mem_rdata = R_WACK;
        tick();
        mem_ready = 1'b0; d_mem_write = 1'b0; d_mem_wdata = '0;
        #1 chk("t3_rel_quiet", {mem_write, grant_d}, 2'b01);
        tick();
        d_mem_read = 1'b1; d_mem_addr = 28'h0000050;
        #1 chk("t3_gap_idle", busy, 1'b0);
        tick();
        chk("t3_i_first", grant_d, 1'b0);
        chk("t3_i_addr", mem_addr, 28'h0000600);
        tick();
        mem_ready = 1'b1; mem_rdata = R_I3;
        tick();
        mem_ready = 1'b0; i_mem_read = 1'b0;
        tick();
        tick();
        chk("t3_alloc_grant", {grant_d, mem_read}, 2'b11);
        chk("t3_alloc_addr", mem_addr, 28'h0000050);
        tick();
        mem_ready = 1'b1; mem_rdata = R_ALLOC;
        tick();
        mem_ready = 1'b0; d_mem_read = 1'b0;
        tick();
        $display("txn wb_then_alloc done at %0t", $time);

        // Spurious ready while idle
        mem_ready = 1'b1; mem_rdata = R_FF;
        #1 chk("t4_readys", {i_mem_ready, d_mem_ready}, 2'b00);
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        #1 chk("t4_hold_i", i_mem_rdata, R_ALLOC);
        chk("t4_hold_d", d_mem_rdata, R_ALLOC);
        $display("txn spurious_ready done at %0t", $time);

        // D aborts before ready
        d_mem_read = 1'b1; d_mem_addr = 28'h0000070;
        tick();
        chk("t5_grant_d", grant_d, 1'b1);
        d_mem_read = 1'b0;
        tick();
        chk("t5_abort_idle", {busy, d_mem_ready}, 2'b00);
        i_mem_read = 1'b1; i_mem_addr = 28'h0000080;
        tick();
        chk("t5_i_grant", {busy, grant_d, mem_read}, 3'b101);
        chk("t5_i_addr", mem_addr, 28'h0000080);
        $display("txn d_abort done at %0t", $time);

        // Asynchronous reset mid-grant
        #1 proc_reset = 1'b1;
        #1 chk("t6_ctrl_zero", {busy, grant_d, mem_read, mem_write, i_mem_ready, d_mem_ready}, 6'b0);
        chk("t6_addr_zero", mem_addr, '0);
        chk("t6_rdata_zero", i_mem_rdata, '0);
        tick();
        d_mem_read = 1'b1; d_mem_addr = 28'h0000090;
        #2 proc_reset = 1'b0;
        tick();
        chk("t6_tie_d", grant_d, 1'b1);
        chk("t6_d_addr", mem_addr, 28'h0000090);
        i_mem_read = 1'b0; d_mem_read = 1'b0;
        tick();
        tick();
        $display("txn reset_mid_grant done at %0t", $time);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
